// File: rtl/params_pkg.sv
// -----------------------------------------------------------------------------
// params_pkg
// Shared constants for the qubit coordinate path: table size, coordinate
// widths, image geometry, the power-up coordinate table and the state
// encoding of the table-commit controller.
// -----------------------------------------------------------------------------
package params_pkg;

    localparam int NUM_QUBITS     = 16;
    localparam int COORD_WIDTH    = 8;
    localparam int QUBIT_ID_WIDTH = 4;
    localparam int IMG_WIDTH      = 256;
    localparam int IMG_HEIGHT     = 256;

    // Power-up coordinates. Every entry sits inside the legal window range
    // (1..IMG_WIDTH-2, 2..IMG_HEIGHT-1) so the matcher is usable out of reset.
    localparam logic [COORD_WIDTH-1:0] DEFAULT_QX [NUM_QUBITS] = '{
        8'd8,   8'd23,  8'd38,  8'd53,  8'd68,  8'd83,  8'd98,  8'd113,
        8'd128, 8'd143, 8'd158, 8'd173, 8'd188, 8'd203, 8'd218, 8'd233
    };
    localparam logic [COORD_WIDTH-1:0] DEFAULT_QY [NUM_QUBITS] = '{
        8'd12,  8'd27,  8'd42,  8'd57,  8'd72,  8'd87,  8'd102, 8'd117,
        8'd132, 8'd147, 8'd162, 8'd177, 8'd192, 8'd207, 8'd222, 8'd237
    };

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SCAN     = 2'd1,
        WAIT_GAP = 2'd2,
        SWAP     = 2'd3
    } ctrl_state_t;

    // Default lookups that stay defined when a design instance is built with
    // more entries than the default table provides (extra entries reset to 0).
    function automatic int default_qx(input int idx);
        if (idx >= 0 && idx < NUM_QUBITS)
            return int'(DEFAULT_QX[idx[QUBIT_ID_WIDTH-1:0]]);
        return 0;
    endfunction

    function automatic int default_qy(input int idx);
        if (idx >= 0 && idx < NUM_QUBITS)
            return int'(DEFAULT_QY[idx[QUBIT_ID_WIDTH-1:0]]);
        return 0;
    endfunction

endpackage

// File: rtl/coord_bounds_check.sv
// -----------------------------------------------------------------------------
// coord_bounds_check
// Combinational legality test of one qubit centre coordinate. A centre is
// legal when its 3x3 window [x-1..x+1] x [y-2..y] lies fully inside the
// image, i.e. 1 <= x <= IMG_WIDTH-2 and 2 <= y <= IMG_HEIGHT-1.
//
// Ports:
//   i_x, i_y  in   COORD_WIDTH  candidate centre coordinate
//   o_ok      out  1            1 when the window fits inside the image
// -----------------------------------------------------------------------------
module coord_bounds_check #(
    parameter int COORD_WIDTH = 8,
    parameter int IMG_WIDTH   = 256,
    parameter int IMG_HEIGHT  = 256
) (
    input  logic [COORD_WIDTH-1:0] i_x,
    input  logic [COORD_WIDTH-1:0] i_y,
    output logic                   o_ok
);

    localparam logic [31:0] X_MIN = 32'd1;
    localparam logic [31:0] X_MAX = 32'(IMG_WIDTH - 2);
    localparam logic [31:0] Y_MIN = 32'd2;
    localparam logic [31:0] Y_MAX = 32'(IMG_HEIGHT - 1);

    // Compare in 32 bits so the limits never wrap for narrow coordinates.
    logic [31:0] w_x;
    logic [31:0] w_y;

    assign w_x  = 32'(i_x);
    assign w_y  = 32'(i_y);
    assign o_ok = (w_x >= X_MIN) && (w_x <= X_MAX) &&
                  (w_y >= Y_MIN) && (w_y <= Y_MAX);

endmodule

// File: rtl/coord_table_ctrl.sv
// -----------------------------------------------------------------------------
// coord_table_ctrl
// Double-buffered qubit coordinate table. Host writes go to a shadow table.
// A commit scans every shadow entry for window legality, waits for the
// inter-frame gap (i_sync_fval low) and then copies the whole shadow table
// into the active table in a single cycle, so the matcher never sees a
// partial or mid-frame update.
//
// Ports:
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_wr_en/addr/x/y          shadow write (accepted only while idle)
//   o_wr_err                  pulse, cycle after a rejected write
//   i_rd_addr, o_rd_x/y       shadow readback, one cycle latency
//   i_commit                  commit request (ignored while busy)
//   i_sync_fval               frame valid; swap waits for it to be low
//   o_q_x, o_q_y              active table to the matcher
//   o_busy                    controller not idle
//   o_commit_done             pulse when the new active table is visible
//   o_commit_err              pulse when the scan finds an illegal entry
//   o_err_index               first failing entry of the last failed scan
//   o_table_gen               count of completed swaps (mod 256)
// -----------------------------------------------------------------------------
module coord_table_ctrl #(
    parameter int NUM_QUBITS     = params_pkg::NUM_QUBITS,
    parameter int COORD_WIDTH    = params_pkg::COORD_WIDTH,
    parameter int QUBIT_ID_WIDTH = params_pkg::QUBIT_ID_WIDTH,
    parameter int IMG_WIDTH      = 256,
    parameter int IMG_HEIGHT     = 256
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_wr_en,
    input  logic [QUBIT_ID_WIDTH-1:0] i_wr_addr,
    input  logic [COORD_WIDTH-1:0]    i_wr_x,
    input  logic [COORD_WIDTH-1:0]    i_wr_y,
    output logic                      o_wr_err,
    input  logic [QUBIT_ID_WIDTH-1:0] i_rd_addr,
    output logic [COORD_WIDTH-1:0]    o_rd_x,
    output logic [COORD_WIDTH-1:0]    o_rd_y,
    input  logic                      i_commit,
    input  logic                      i_sync_fval,
    output logic [COORD_WIDTH-1:0]    o_q_x [NUM_QUBITS],
    output logic [COORD_WIDTH-1:0]    o_q_y [NUM_QUBITS],
    output logic                      o_busy,
    output logic                      o_commit_done,
    output logic                      o_commit_err,
    output logic [QUBIT_ID_WIDTH-1:0] o_err_index,
    output logic [7:0]                o_table_gen
);

    localparam logic [31:0]               NQ_U   = 32'(NUM_QUBITS);
    localparam logic [QUBIT_ID_WIDTH-1:0] LAST_K = QUBIT_ID_WIDTH'(NUM_QUBITS - 1);

    // ---------------------------------------------------------------------
    // Storage
    // ---------------------------------------------------------------------
    logic [COORD_WIDTH-1:0] r_shadow_x [NUM_QUBITS];
    logic [COORD_WIDTH-1:0] r_shadow_y [NUM_QUBITS];
    logic [COORD_WIDTH-1:0] r_active_x [NUM_QUBITS];
    logic [COORD_WIDTH-1:0] r_active_y [NUM_QUBITS];
    logic [COORD_WIDTH-1:0] w_rst_x    [NUM_QUBITS];
    logic [COORD_WIDTH-1:0] w_rst_y    [NUM_QUBITS];
    logic [NUM_QUBITS-1:0]  w_wr_hit;

    // ---------------------------------------------------------------------
    // Control state
    // ---------------------------------------------------------------------
    params_pkg::ctrl_state_t   r_state;
    logic [QUBIT_ID_WIDTH-1:0] r_k;
    logic                      r_busy;
    logic                      r_wr_err;
    logic                      r_commit_done;
    logic                      r_commit_err;
    logic [QUBIT_ID_WIDTH-1:0] r_err_index;
    logic [7:0]                r_table_gen;
    logic [COORD_WIDTH-1:0]    r_rd_x;
    logic [COORD_WIDTH-1:0]    r_rd_y;

    logic                      w_idle;
    logic                      w_wr_addr_ok;
    logic                      w_rd_addr_ok;
    logic                      w_wr_accept;
    logic                      w_swap;
    logic                      w_scan_ok;
    logic [COORD_WIDTH-1:0]    w_scan_x;
    logic [COORD_WIDTH-1:0]    w_scan_y;

    assign w_idle       = (r_state == params_pkg::IDLE);
    assign w_swap       = (r_state == params_pkg::SWAP);
    assign w_wr_addr_ok = (32'(i_wr_addr) < NQ_U);
    assign w_rd_addr_ok = (32'(i_rd_addr) < NQ_U);
    // Writes are frozen for the whole commit so the scanned contents are
    // exactly the contents that get swapped.
    assign w_wr_accept  = i_wr_en && w_idle && w_wr_addr_ok;

    // ---------------------------------------------------------------------
    // Per-entry reset values, write decode and active-table outputs
    // ---------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_QUBITS; gi++) begin : g_entry
            assign w_rst_x[gi]  = COORD_WIDTH'(params_pkg::default_qx(gi));
            assign w_rst_y[gi]  = COORD_WIDTH'(params_pkg::default_qy(gi));
            assign w_wr_hit[gi] = w_wr_accept && (32'(i_wr_addr) == 32'(gi));
            assign o_q_x[gi]    = r_active_x[gi];
            assign o_q_y[gi]    = r_active_y[gi];
        end
    endgenerate

    // Shadow and active tables. The active copy happens for all entries on
    // the single SWAP edge, so it is a register bank rather than a RAM.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < NUM_QUBITS; i++) begin
            if (i_rst) begin
                r_shadow_x[i] <= w_rst_x[i];
                r_shadow_y[i] <= w_rst_y[i];
                r_active_x[i] <= w_rst_x[i];
                r_active_y[i] <= w_rst_y[i];
            end else begin
                if (w_wr_hit[i]) begin
                    r_shadow_x[i] <= i_wr_x;
                    r_shadow_y[i] <= i_wr_y;
                end
                if (w_swap) begin
                    r_active_x[i] <= r_shadow_x[i];
                    r_active_y[i] <= r_shadow_y[i];
                end
            end
        end
    end

    // Registered shadow readback; out-of-range addresses read as zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_x <= '0;
            r_rd_y <= '0;
        end else if (w_rd_addr_ok) begin
            r_rd_x <= r_shadow_x[i_rd_addr];
            r_rd_y <= r_shadow_y[i_rd_addr];
        end else begin
            r_rd_x <= '0;
            r_rd_y <= '0;
        end
    end

    // ---------------------------------------------------------------------
    // Scan: one shared bounds checker, walked across the table by r_k
    // ---------------------------------------------------------------------
    assign w_scan_x = r_shadow_x[r_k];
    assign w_scan_y = r_shadow_y[r_k];

    coord_bounds_check #(
        .COORD_WIDTH (COORD_WIDTH),
        .IMG_WIDTH   (IMG_WIDTH),
        .IMG_HEIGHT  (IMG_HEIGHT)
    ) u_bounds (
        .i_x  (w_scan_x),
        .i_y  (w_scan_y),
        .o_ok (w_scan_ok)
    );

    // ---------------------------------------------------------------------
    // Commit FSM with registered status outputs
    // ---------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= params_pkg::IDLE;
            r_k           <= '0;
            r_busy        <= 1'b0;
            r_wr_err      <= 1'b0;
            r_commit_done <= 1'b0;
            r_commit_err  <= 1'b0;
            r_err_index   <= '0;
            r_table_gen   <= '0;
        end else begin
            r_commit_done <= 1'b0;
            r_commit_err  <= 1'b0;
            r_wr_err      <= i_wr_en && !w_wr_accept;

            case (r_state)
                params_pkg::IDLE: begin
                    if (i_commit) begin
                        r_state <= params_pkg::SCAN;
                        r_k     <= '0;
                        r_busy  <= 1'b1;
                    end
                end

                params_pkg::SCAN: begin
                    if (!w_scan_ok) begin
                        // Abort without touching the active table.
                        r_state      <= params_pkg::IDLE;
                        r_busy       <= 1'b0;
                        r_commit_err <= 1'b1;
                        r_err_index  <= r_k;
                    end else if (r_k == LAST_K) begin
                        r_state <= params_pkg::WAIT_GAP;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end

                params_pkg::WAIT_GAP: begin
                    if (!i_sync_fval) begin
                        r_state <= params_pkg::SWAP;
                    end
                end

                params_pkg::SWAP: begin
                    r_state       <= params_pkg::IDLE;
                    r_busy        <= 1'b0;
                    r_commit_done <= 1'b1;
                    r_table_gen   <= r_table_gen + 8'd1;
                end

                default: begin
                    r_state <= params_pkg::IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy        = r_busy;
    assign o_wr_err      = r_wr_err;
    assign o_commit_done = r_commit_done;
    assign o_commit_err  = r_commit_err;
    assign o_err_index   = r_err_index;
    assign o_table_gen   = r_table_gen;
    assign o_rd_x        = r_rd_x;
    assign o_rd_y        = r_rd_y;

endmodule
